// File: rtl/mem_arbiter.sv
// Two-port (instruction/data) arbiter onto a single external memory port,
// one outstanding transaction, data priority with instruction starvation guard.
module mem_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        if_req_valid,
  input  logic [31:0] if_req_addr,
  output logic        if_req_ready,
  input  logic        if_flush,
  output logic        if_resp_valid,
  output logic [31:0] if_resp_data,
  input  logic        dm_req_valid,
  input  logic [31:0] dm_req_addr,
  input  logic        dm_req_we,
  input  logic [31:0] dm_req_wdata,
  input  logic [3:0]  dm_req_wstrb,
  output logic        dm_req_ready,
  output logic        dm_resp_valid,
  output logic [31:0] dm_resp_data,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic [31:0] mem_req_addr,
  output logic        mem_req_we,
  output logic [31:0] mem_req_wdata,
  output logic [3:0]  mem_req_wstrb,
  input  logic        mem_resp_valid,
  input  logic [31:0] mem_resp_data
);

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned SW = 4;
  localparam int unsigned CW = 4;

  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;
  typedef enum logic {OWN_DATA, OWN_INSTR} owner_t;

  state_t        state_q, state_d;
  owner_t        owner_q;
  logic [CW-1:0] starve_q;
  logic          flush_q;
  logic [AW-1:0] addr_q;
  logic          we_q;
  logic [DW-1:0] wdata_q;
  logic [SW-1:0] wstrb_q;

  logic if_elig;
  logic grant_if;
  logic grant_dm;
  logic resp_drop;

  assign mem_req_addr  = addr_q;
  assign mem_req_we    = we_q;
  assign mem_req_wdata = wdata_q;
  assign mem_req_wstrb = wstrb_q;

  // Next-state, grant decision and combinational handshake outputs.
  always_comb begin
    state_d       = state_q;
    grant_if      = 1'b0;
    grant_dm      = 1'b0;
    resp_drop     = 1'b0;
    mem_req_valid = 1'b0;
    if_elig       = if_req_valid && !if_flush;
    unique case (state_q)
      IDLE: begin
        if (!reset) begin
          if (if_elig && (!dm_req_valid || starve_q >= CW'(STARVE_LIMIT))) begin
            grant_if = 1'b1;
          end else if (dm_req_valid) begin
            grant_dm = 1'b1;
          end
          if (grant_if || grant_dm) begin
            state_d = REQ;
          end
        end
      end
      REQ: begin
        mem_req_valid = 1'b1;
        if (mem_req_ready) begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (mem_resp_valid) begin
          state_d   = IDLE;
          resp_drop = (owner_q == OWN_INSTR) && (flush_q || if_flush);
        end
      end
      default: state_d = IDLE;
    endcase
    if_req_ready = grant_if;
    dm_req_ready = grant_dm;
  end

  // State, latched request, starvation counter, flush tracking and responses.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      owner_q       <= OWN_DATA;
      starve_q      <= '0;
      flush_q       <= 1'b0;
      addr_q        <= '0;
      we_q          <= 1'b0;
      wdata_q       <= '0;
      wstrb_q       <= '0;
      if_resp_valid <= 1'b0;
      if_resp_data  <= '0;
      dm_resp_valid <= 1'b0;
      dm_resp_data  <= '0;
    end else begin
      state_q       <= state_d;
      if_resp_valid <= 1'b0;
      dm_resp_valid <= 1'b0;

      if (grant_if || grant_dm) begin
        owner_q <= grant_if ? OWN_INSTR : OWN_DATA;
        addr_q  <= grant_if ? if_req_addr : dm_req_addr;
        we_q    <= grant_dm && dm_req_we;
        wdata_q <= grant_if ? '0 : dm_req_wdata;
        wstrb_q <= (grant_dm && dm_req_we) ? dm_req_wstrb : SW'(4'hF);
      end

      // Counts data wins that happened while an instruction request was pending.
      if (grant_if) begin
        starve_q <= '0;
      end else if (grant_dm && if_req_valid && starve_q != CW'(4'hF)) begin
        starve_q <= starve_q + CW'(1);
      end

      if (state_d == IDLE) begin
        flush_q <= 1'b0;
      end else if (state_q != IDLE && owner_q == OWN_INSTR && if_flush) begin
        flush_q <= 1'b1;
      end

      if (state_q == WAIT && mem_resp_valid) begin
        if (owner_q == OWN_DATA) begin
          dm_resp_valid <= 1'b1;
          dm_resp_data  <= we_q ? '0 : mem_resp_data;
        end else if (!resp_drop) begin
          if_resp_valid <= 1'b1;
          if_resp_data  <= mem_resp_data;
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: cycle vector table, directed corner
// sequences, and randomized transactions against a transaction-level model.
module tb_mem_arbiter;

  localparam int unsigned LIMIT = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        if_req_valid;
  logic [31:0] if_req_addr;
  logic        if_req_ready;
  logic        if_flush;
  logic        if_resp_valid;
  logic [31:0] if_resp_data;
  logic        dm_req_valid;
  logic [31:0] dm_req_addr;
  logic        dm_req_we;
  logic [31:0] dm_req_wdata;
  logic [3:0]  dm_req_wstrb;
  logic        dm_req_ready;
  logic        dm_resp_valid;
  logic [31:0] dm_resp_data;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [31:0] mem_req_addr;
  logic        mem_req_we;
  logic [31:0] mem_req_wdata;
  logic [3:0]  mem_req_wstrb;
  logic        mem_resp_valid;
  logic [31:0] mem_resp_data;

  int n_checks = 0;
  int n_fail   = 0;
  int m_starve = 0;

  mem_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .reset(reset),
    .if_req_valid(if_req_valid), .if_req_addr(if_req_addr), .if_req_ready(if_req_ready),
    .if_flush(if_flush), .if_resp_valid(if_resp_valid), .if_resp_data(if_resp_data),
    .dm_req_valid(dm_req_valid), .dm_req_addr(dm_req_addr), .dm_req_we(dm_req_we),
    .dm_req_wdata(dm_req_wdata), .dm_req_wstrb(dm_req_wstrb), .dm_req_ready(dm_req_ready),
    .dm_resp_valid(dm_resp_valid), .dm_resp_data(dm_resp_data),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
    .mem_req_we(mem_req_we), .mem_req_wdata(mem_req_wdata), .mem_req_wstrb(mem_req_wstrb),
    .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        if_v, flush, dm_v, dm_we, mrdy, mrv;
    logic [31:0] mrdata;
    logic        e_ifr, e_dmr, e_mv;
    logic [31:0] e_maddr;
    logic        e_mwe;
    logic [3:0]  e_mwstrb;
    logic        e_ifv, e_dmv;
    logic [31:0] e_rdata;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic add(input logic if_v, flush, dm_v, dm_we, mrdy, mrv, input logic [31:0] mrdata,
                     input logic e_ifr, e_dmr, e_mv, input logic [31:0] e_maddr,
                     input logic e_mwe, input logic [3:0] e_mwstrb,
                     input logic e_ifv, e_dmv, input logic [31:0] e_rdata);
    vec_t v;
    v.if_v = if_v; v.flush = flush; v.dm_v = dm_v; v.dm_we = dm_we; v.mrdy = mrdy; v.mrv = mrv;
    v.mrdata = mrdata; v.e_ifr = e_ifr; v.e_dmr = e_dmr; v.e_mv = e_mv; v.e_maddr = e_maddr;
    v.e_mwe = e_mwe; v.e_mwstrb = e_mwstrb; v.e_ifv = e_ifv; v.e_dmv = e_dmv; v.e_rdata = e_rdata;
    vecs.push_back(v);
  endtask

  task automatic idle_in();
    if_req_valid = 0; if_flush = 0; dm_req_valid = 0; dm_req_we = 0;
    mem_req_ready = 0; mem_resp_valid = 0; mem_resp_data = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    idle_in();
    reset = 1;
    @(negedge clk);
    @(negedge clk);
    reset = 0;
    m_starve = 0;
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_ifr"}, 32'(if_req_ready), 0);
    chk({tag, "_dmr"}, 32'(dm_req_ready), 0);
    chk({tag, "_mv"},  32'(mem_req_valid), 0);
    chk({tag, "_ifv"}, 32'(if_resp_valid), 0);
    chk({tag, "_dmv"}, 32'(dm_resp_valid), 0);
  endtask

  // One randomized transaction, predicted from the arbitration rules alone.
  task automatic rnd_txn(input int n);
    logic iv, dv, fl0, we, ive, win_i, dropped;
    logic [31:0] ia, da, wd, rd, e_addr;
    logic [3:0] ws;
    int stall, dly;
    @(negedge clk);
    iv = 1'($urandom % 2); dv = 1'($urandom % 2); fl0 = ($urandom % 4) == 0;
    we = 1'($urandom % 2);
    ia = $urandom; da = $urandom; wd = $urandom; rd = $urandom; ws = 4'($urandom);
    if_req_valid = iv; if_req_addr = ia; if_flush = fl0;
    dm_req_valid = dv; dm_req_addr = da; dm_req_we = we; dm_req_wdata = wd; dm_req_wstrb = ws;
    #2;
    ive = iv && !fl0;
    win_i = ive && (!dv || m_starve >= int'(LIMIT));
    chk($sformatf("rnd%0d_ifr", n), 32'(if_req_ready), 32'(win_i));
    chk($sformatf("rnd%0d_dmr", n), 32'(dm_req_ready), 32'(dv && !win_i));
    if (!ive && !dv) return;
    if (win_i) m_starve = 0;
    else if (iv && m_starve < 15) m_starve++;
    e_addr = win_i ? ia : da;
    dropped = 0;
    stall = $urandom_range(0, 2);
    dly = $urandom_range(0, 2);
    for (int c = 0; c <= stall; c++) begin
      @(negedge clk);
      idle_in();
      mem_req_ready = (c == stall);
      mem_resp_valid = (c != stall) && (($urandom % 3) == 0);
      mem_resp_data = $urandom;
      if_flush = ($urandom % 4) == 0;
      if (win_i && if_flush) dropped = 1;
      #2;
      chk($sformatf("rnd%0d_mv", n), 32'(mem_req_valid), 1);
      chk($sformatf("rnd%0d_addr", n), mem_req_addr, e_addr);
      chk($sformatf("rnd%0d_we", n), 32'(mem_req_we), 32'(!win_i && we));
      chk($sformatf("rnd%0d_wstrb", n), 32'(mem_req_wstrb), 32'((!win_i && we) ? ws : 4'hF));
    end
    for (int c = 0; c <= dly; c++) begin
      @(negedge clk);
      idle_in();
      mem_resp_valid = (c == dly);
      mem_resp_data = rd;
      if_flush = ($urandom % 4) == 0;
      if (win_i && if_flush) dropped = 1;
      #2;
      chk_quiet($sformatf("rnd%0d_wait", n));
    end
    @(negedge clk);
    idle_in();
    #2;
    chk($sformatf("rnd%0d_ifv", n), 32'(if_resp_valid), 32'(win_i && !dropped));
    chk($sformatf("rnd%0d_dmv", n), 32'(dm_resp_valid), 32'(!win_i));
    if (win_i && !dropped) chk($sformatf("rnd%0d_ifdata", n), if_resp_data, rd);
    if (!win_i) chk($sformatf("rnd%0d_dmdata", n), dm_resp_data, we ? 32'h0 : rd);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish (got timeout, expected $finish)");
    $fatal(1);
  end

  initial begin
    logic exp_i [6];
    int   exp_cnt [6];
    reset = 1;
    idle_in();
    if_req_addr = 32'h100; dm_req_addr = 32'h2000;
    dm_req_wdata = 32'hDEADBEEF; dm_req_wstrb = 4'b0011;
    do_reset();

    // Reset state
    #2;
    chk_quiet("reset");
    chk("reset_maddr", mem_req_addr, 0);
    chk("reset_mwstrb", 32'(mem_req_wstrb), 0);
    chk("reset_ifdata", if_resp_data, 0);
    chk("reset_dmdata", dm_resp_data, 0);

    //  if fl dm we rdy rv data          ifr dmr mv addr          we strb  ifv dmv rdata
    add(1, 0, 0, 0, 0, 0, 32'h0,        1, 0, 0, 32'h0,    0, 4'h0, 0, 0, 32'h0);
    add(0, 0, 0, 0, 1, 0, 32'h0,        0, 0, 1, 32'h100,  0, 4'hF, 0, 0, 32'h0);
    add(0, 0, 0, 0, 0, 1, 32'h00500093, 0, 0, 0, 32'h0,    0, 4'h0, 0, 0, 32'h0);
    add(0, 0, 0, 0, 0, 0, 32'h0,        0, 0, 0, 32'h0,    0, 4'h0, 1, 0, 32'h00500093);
    add(0, 0, 1, 1, 0, 0, 32'h0,        0, 1, 0, 32'h0,    0, 4'h0, 0, 0, 32'h0);
    add(0, 0, 0, 0, 0, 0, 32'h0,        0, 0, 1, 32'h2000, 1, 4'h3, 0, 0, 32'h0);
    add(0, 0, 0, 0, 0, 0, 32'h0,        0, 0, 1, 32'h2000, 1, 4'h3, 0, 0, 32'h0);
    add(0, 0, 0, 0, 0, 0, 32'h0,        0, 0, 1, 32'h2000, 1, 4'h3, 0, 0, 32'h0);
    add(0, 0, 0, 0, 1, 0, 32'h0,        0, 0, 1, 32'h2000, 1, 4'h3, 0, 0, 32'h0);
    add(0, 0, 0, 0, 0, 1, 32'h12345678, 0, 0, 0, 32'h0,    0, 4'h0, 0, 0, 32'h0);
    add(0, 0, 0, 0, 0, 0, 32'h0,        0, 0, 0, 32'h0,    0, 4'h0, 0, 1, 32'h0);
    add(1, 1, 0, 0, 0, 0, 32'h0,        0, 0, 0, 32'h0,    0, 4'h0, 0, 0, 32'h0);
    add(1, 1, 0, 0, 0, 0, 32'h0,        0, 0, 0, 32'h0,    0, 4'h0, 0, 0, 32'h0);
    add(1, 0, 0, 0, 0, 0, 32'h0,        1, 0, 0, 32'h0,    0, 4'h0, 0, 0, 32'h0);
    add(0, 0, 0, 0, 1, 0, 32'h0,        0, 0, 1, 32'h100,  0, 4'hF, 0, 0, 32'h0);
    add(0, 0, 0, 0, 0, 1, 32'h11112222, 0, 0, 0, 32'h0,    0, 4'h0, 0, 0, 32'h0);
    add(0, 0, 0, 0, 0, 0, 32'h0,        0, 0, 0, 32'h0,    0, 4'h0, 1, 0, 32'h11112222);
    add(1, 0, 0, 0, 0, 0, 32'h0,        1, 0, 0, 32'h0,    0, 4'h0, 0, 0, 32'h0);
    add(0, 0, 0, 0, 1, 0, 32'h0,        0, 0, 1, 32'h100,  0, 4'hF, 0, 0, 32'h0);
    add(0, 1, 1, 0, 0, 0, 32'h0,        0, 0, 0, 32'h0,    0, 4'h0, 0, 0, 32'h0);
    add(0, 0, 1, 0, 0, 1, 32'hAAAA5555, 0, 0, 0, 32'h0,    0, 4'h0, 0, 0, 32'h0);
    add(0, 0, 1, 0, 0, 0, 32'h0,        0, 1, 0, 32'h0,    0, 4'h0, 0, 0, 32'h0);
    add(0, 0, 0, 0, 1, 0, 32'h0,        0, 0, 1, 32'h2000, 0, 4'hF, 0, 0, 32'h0);
    add(0, 0, 0, 0, 0, 1, 32'hCAFE0001, 0, 0, 0, 32'h0,    0, 4'h0, 0, 0, 32'h0);
    add(0, 0, 0, 0, 0, 0, 32'h0,        0, 0, 0, 32'h0,    0, 4'h0, 0, 1, 32'hCAFE0001);

    foreach (vecs[i]) begin
      @(negedge clk);
      if_req_valid = vecs[i].if_v; if_flush = vecs[i].flush;
      dm_req_valid = vecs[i].dm_v; dm_req_we = vecs[i].dm_we;
      mem_req_ready = vecs[i].mrdy; mem_resp_valid = vecs[i].mrv; mem_resp_data = vecs[i].mrdata;
      #2;
      chk($sformatf("vec%0d_ifr", i), 32'(if_req_ready), 32'(vecs[i].e_ifr));
      chk($sformatf("vec%0d_dmr", i), 32'(dm_req_ready), 32'(vecs[i].e_dmr));
      chk($sformatf("vec%0d_mv", i), 32'(mem_req_valid), 32'(vecs[i].e_mv));
      chk($sformatf("vec%0d_ifv", i), 32'(if_resp_valid), 32'(vecs[i].e_ifv));
      chk($sformatf("vec%0d_dmv", i), 32'(dm_resp_valid), 32'(vecs[i].e_dmv));
      if (vecs[i].e_mv) begin
        chk($sformatf("vec%0d_addr", i), mem_req_addr, vecs[i].e_maddr);
        chk($sformatf("vec%0d_we", i), 32'(mem_req_we), 32'(vecs[i].e_mwe));
        chk($sformatf("vec%0d_wstrb", i), 32'(mem_req_wstrb), 32'(vecs[i].e_mwstrb));
      end
      if (vecs[i].e_ifv) chk($sformatf("vec%0d_ifdata", i), if_resp_data, vecs[i].e_rdata);
      if (vecs[i].e_dmv) chk($sformatf("vec%0d_dmdata", i), dm_resp_data, vecs[i].e_rdata);
    end

    // Contention: both ports request continuously
    do_reset();
    exp_i = '{0, 0, 1, 0, 0, 1};
    exp_cnt = '{0, 1, 2, 0, 1, 2};
    for (int g = 0; g < 6; g++) begin
      @(negedge clk);
      idle_in();
      if_req_valid = 1; dm_req_valid = 1;
      #2;
      chk($sformatf("cont%0d_ifr", g), 32'(if_req_ready), 32'(exp_i[g]));
      chk($sformatf("cont%0d_dmr", g), 32'(dm_req_ready), 32'(!exp_i[g]));
      chk($sformatf("cont%0d_starve", g), 32'(dut.starve_q), 32'(exp_cnt[g]));
      @(negedge clk);
      mem_req_ready = 1;
      @(negedge clk);
      mem_req_ready = 0; mem_resp_valid = 1; mem_resp_data = 32'(g);
    end

    // Reset while waiting for a response; late response must be ignored
    do_reset();
    @(negedge clk);
    dm_req_valid = 1; dm_req_we = 0; dm_req_addr = 32'h4000;
    #2;
    chk("rstw_dmr", 32'(dm_req_ready), 1);
    @(negedge clk);
    dm_req_valid = 0; mem_req_ready = 1;
    #2;
    chk("rstw_mv", 32'(mem_req_valid), 1);
    @(negedge clk);
    mem_req_ready = 0; reset = 1;
    @(negedge clk);
    reset = 0;
    #2;
    chk_quiet("rstw_after");
    @(negedge clk);
    @(negedge clk);
    mem_resp_valid = 1; mem_resp_data = 32'hBAD0BAD0;
    #2;
    chk_quiet("rstw_late");
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      idle_in();
      #2;
      chk_quiet($sformatf("rstw_post%0d", c));
    end
    @(negedge clk);
    if_req_valid = 1; if_req_addr = 32'h300;
    #2;
    chk("rstw_fetch_ifr", 32'(if_req_ready), 1);
    @(negedge clk);
    idle_in(); mem_req_ready = 1;
    #2;
    chk("rstw_fetch_addr", mem_req_addr, 32'h300);
    @(negedge clk);
    idle_in(); mem_resp_valid = 1; mem_resp_data = 32'h0BADF00D;
    @(negedge clk);
    idle_in();
    #2;
    chk("rstw_fetch_ifv", 32'(if_resp_valid), 1);
    chk("rstw_fetch_data", if_resp_data, 32'h0BADF00D);

    // Randomized transactions against the model
    do_reset();
    for (int n = 0; n < 300; n++) rnd_txn(n);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
